// File: rtl/ht_cmd_player.sv
// ht_cmd_player: replays a programmed list of hash-table commands through a
// valid/ready task port and counts results. Optional looping: HT_PLAYER_LOOP_EN.
package ht_cmd_player_pkg;
  typedef enum logic [1:0] {
    HT_SEARCH = 2'd0,
    HT_INSERT = 2'd1,
    HT_DELETE = 2'd2
  } ht_cmd_t;
endpackage

module ht_cmd_player
  import ht_cmd_player_pkg::*;
#(
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 16,
  parameter int DEPTH       = 16,
  parameter int GAP_W       = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_valid_i,
  input  logic [AW-1:0]          load_addr_i,
  input  logic [KEY_WIDTH-1:0]   load_key_i,
  input  logic [VALUE_WIDTH-1:0] load_value_i,
  input  ht_cmd_t                load_cmd_i,
  input  logic [GAP_W-1:0]       load_gap_i,
  input  logic [NW-1:0]          num_cmds_i,
  input  logic                   start_i,
  input  logic                   loop_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [KEY_WIDTH-1:0]   task_key_o,
  output logic [VALUE_WIDTH-1:0] task_value_o,
  output ht_cmd_t                task_cmd_o,
  output logic                   task_valid_o,
  input  logic                   task_ready_i,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  output logic [15:0]            sent_cnt_o,
  output logic [15:0]            recv_cnt_o
);

  typedef struct packed {
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
    ht_cmd_t                cmd;
    logic [GAP_W-1:0]       gap;
  } slot_t;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  slot_t            mem [DEPTH];
  state_t           state, state_nxt;
  logic [AW-1:0]    ptr, ptr_adv, ld_idx;
  logic [NW-1:0]    n_lat, n_clamp;
  logic [GAP_W-1:0] cnt, cur_gap;
  logic             hs, last, wrap, ld_en, valid_d, busy_d, done_d;
  logic [15:0]      sent_nxt, recv_nxt;

  // Program RAM is not reset; contents survive rst_i.
  always_ff @(posedge clk_i)
    if (load_valid_i && !busy_o)
      mem[load_addr_i] <= '{key: load_key_i, value: load_value_i,
                            cmd: load_cmd_i, gap: load_gap_i};

  assign res_ready_o = 1'b1;
  assign hs          = task_valid_o && task_ready_i;
  assign cur_gap     = mem[ptr].gap;
  assign last        = NW'(ptr) == n_lat - NW'(1);
  assign ptr_adv     = last ? '0 : ptr + AW'(1);
  assign n_clamp     = (num_cmds_i > NW'(DEPTH)) ? NW'(DEPTH) : num_cmds_i;

`ifdef HT_PLAYER_LOOP_EN
  assign wrap = loop_i;
`else
  logic unused_loop;
  assign unused_loop = loop_i;
  assign wrap        = 1'b0;
`endif

  always_comb begin
    sent_nxt = sent_cnt_o;
    recv_nxt = recv_cnt_o;
    if (hs && sent_cnt_o != CNT_MAX) sent_nxt = sent_cnt_o + 16'd1;
    if (res_valid_i && res_ready_o && recv_cnt_o != CNT_MAX) recv_nxt = recv_cnt_o + 16'd1;
  end

  always_ff @(posedge clk_i)
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_i) state_nxt = (n_clamp == '0) ? S_DONE : S_SEND;
      S_SEND:  if (hs) begin
                 if (last && !wrap)     state_nxt = S_DRAIN;
                 else if (cur_gap != '0) state_nxt = S_GAP;
               end
      S_GAP:   if (cnt == GAP_W'(1)) state_nxt = S_SEND;
      // Compare against the next recv value so done_o follows the last result by one cycle.
      S_DRAIN: if (recv_nxt == sent_cnt_o) state_nxt = S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; S_DONE only holds an empty run open one cycle.
  always_comb begin
    valid_d = (state_nxt == S_SEND);
    busy_d  = (state_nxt != S_IDLE);
    done_d  = (state == S_DONE) || (state == S_DRAIN && state_nxt == S_IDLE);
    ld_en   = 1'b0;
    ld_idx  = ptr;
    case (state)
      S_IDLE: if (start_i && n_clamp != '0) begin ld_en = 1'b1; ld_idx = '0;      end
      S_SEND: if (hs && state_nxt == S_SEND) begin ld_en = 1'b1; ld_idx = ptr_adv; end
      S_GAP:  if (state_nxt == S_SEND)       begin ld_en = 1'b1; ld_idx = ptr;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      task_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      task_key_o   <= '0;
      task_value_o <= '0;
      task_cmd_o   <= HT_SEARCH;
      sent_cnt_o   <= '0;
      recv_cnt_o   <= '0;
      ptr          <= '0;
      n_lat        <= '0;
      cnt          <= '0;
    end else begin
      task_valid_o <= valid_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      if (state == S_IDLE && start_i) begin
        n_lat      <= n_clamp;
        ptr        <= '0;
        sent_cnt_o <= '0;
        recv_cnt_o <= '0;
      end else begin
        sent_cnt_o <= sent_nxt;
        recv_cnt_o <= recv_nxt;
      end
      // After a handshake ptr names the next slot to present, even across a gap.
      if (hs) begin
        ptr <= ptr_adv;
        cnt <= cur_gap;
      end else if (state == S_GAP) begin
        cnt <= cnt - GAP_W'(1);
      end
      if (ld_en) begin
        task_key_o   <= mem[ld_idx].key;
        task_value_o <= mem[ld_idx].value;
        task_cmd_o   <= mem[ld_idx].cmd;
      end
    end
  end

endmodule

// File: tb/tb_ht_cmd_player.sv
// Directed self-checking bench for ht_cmd_player (DEPTH=4 so clamping is reachable).
module tb_ht_cmd_player;
  import ht_cmd_player_pkg::*;

  localparam int KW = 32, VW = 16, DEPTH = 4, GW = 8, AW = 2, NW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          load_valid, start, loop, task_ready, res_valid;
  logic [AW-1:0] load_addr;
  logic [KW-1:0] load_key;
  logic [VW-1:0] load_value;
  ht_cmd_t       load_cmd;
  logic [GW-1:0] load_gap;
  logic [NW-1:0] num_cmds;
  logic          busy, done, task_valid, res_ready;
  logic [KW-1:0] task_key;
  logic [VW-1:0] task_value;
  ht_cmd_t       task_cmd;
  logic [15:0]   sent_cnt, recv_cnt;

  logic [KW-1:0] kk [4];
  logic [VW-1:0] vv [4];
  int n_cmp = 0, n_err = 0, idle;

  always #5 clk = ~clk;

  ht_cmd_player #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .DEPTH(DEPTH), .GAP_W(GW)) dut (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(load_valid), .load_addr_i(load_addr), .load_key_i(load_key),
    .load_value_i(load_value), .load_cmd_i(load_cmd), .load_gap_i(load_gap),
    .num_cmds_i(num_cmds), .start_i(start), .loop_i(loop),
    .busy_o(busy), .done_o(done),
    .task_key_o(task_key), .task_value_o(task_value), .task_cmd_o(task_cmd),
    .task_valid_o(task_valid), .task_ready_i(task_ready),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .sent_cnt_o(sent_cnt), .recv_cnt_o(recv_cnt)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input int s, input ht_cmd_t c, input int g);
    load_valid = 1'b1; load_addr = AW'(a); load_key = kk[s]; load_value = vv[s];
    load_cmd = c; load_gap = GW'(g);
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic go(input int n);
    num_cmds = NW'(n); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    kk[0] = 32'h01000000; vv[0] = 16'h1234;
    kk[1] = 32'h01000001; vv[1] = 16'h1235;
    kk[2] = 32'h01000002; vv[2] = 16'h1236;
    kk[3] = 32'h01000003; vv[3] = 16'h1237;
    load_valid = 0; load_addr = '0; load_key = '0; load_value = '0; load_cmd = HT_SEARCH;
    load_gap = '0; num_cmds = '0; start = 0; loop = 0; task_ready = 1; res_valid = 0;
    cyc(); cyc();
    chk("rst_valid", task_valid, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_key", task_key, 0); chk("rst_value", task_value, 0); chk("rst_cmd", 64'(task_cmd), 0);
    chk("rst_sent", sent_cnt, 0); chk("rst_recv", recv_cnt, 0); chk("rst_res_ready", res_ready, 1);
    rst = 0;
    load(0, 0, HT_INSERT, 0); load(1, 1, HT_INSERT, 0);
    load(2, 2, HT_DELETE, 0); load(3, 3, HT_SEARCH, 0);

    // back-to-back pair, one result per command
    go(2);
    chk("t1_valid0", task_valid, 1); chk("t1_busy", busy, 1); chk("t1_key0", task_key, kk[0]);
    chk("t1_val0", task_value, vv[0]); chk("t1_cmd0", 64'(task_cmd), 64'(HT_INSERT));
    cyc();
    chk("t1_valid1", task_valid, 1); chk("t1_key1", task_key, kk[1]); chk("t1_sent1", sent_cnt, 1);
    res_valid = 1; cyc();
    chk("t1_drain_valid", task_valid, 0); chk("t1_sent2", sent_cnt, 2); chk("t1_recv1", recv_cnt, 1);
    chk("t1_drain_done", done, 0);
    cyc();
    chk("t1_done", done, 1); chk("t1_busy_low", busy, 0); chk("t1_recv2", recv_cnt, 2);
    res_valid = 0; cyc();
    chk("t1_done_pulse", done, 0);

    // ready stall on slot 0
    task_ready = 0; go(2);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", task_valid, 1); chk("t2_stall_key", task_key, kk[0]);
      chk("t2_stall_val", task_value, vv[0]); chk("t2_stall_sent", sent_cnt, 0);
      cyc();
    end
    chk("t2_key_hold", task_key, kk[0]);
    task_ready = 1; cyc();
    chk("t2_key1", task_key, kk[1]); chk("t2_sent1", sent_cnt, 1);
    res_valid = 1; cyc();
    chk("t2_drain_valid", task_valid, 0); chk("t2_sent2", sent_cnt, 2);
    cyc();
    chk("t2_done", done, 1); chk("t2_recv2", recv_cnt, 2);
    res_valid = 0; cyc();

    // gap of 5 after slot 0; results land during the gap
    load(0, 0, HT_INSERT, 5);
    go(2);
    chk("t3_valid0", task_valid, 1);
    cyc(); res_valid = 1;
    idle = 0;
    for (int i = 0; i < 10 && !task_valid; i++) begin
      idle++;
      if (i == 2) res_valid = 0;
      cyc();
    end
    chk("t3_gap_cycles", idle, 5); chk("t3_key1", task_key, kk[1]); chk("t3_recv_early", recv_cnt, 2);
    cyc();
    chk("t3_drain_valid", task_valid, 0); chk("t3_drain_done", done, 0); chk("t3_drain_busy", busy, 1);
    cyc();
    chk("t3_done", done, 1); chk("t3_busy_low", busy, 0);
    cyc();

    // N=0, with a start while the empty run is still busy
    go(0);
    chk("t4_busy", busy, 1); chk("t4_valid", task_valid, 0); chk("t4_done_early", done, 0);
    num_cmds = 2; start = 1; cyc(); start = 0;
    chk("t4_done", done, 1); chk("t4_busy_low", busy, 0); chk("t4_sent", sent_cnt, 0);
    chk("t4_recv", recv_cnt, 0); chk("t4_valid2", task_valid, 0);
    cyc();
    chk("t4_start_ignored_busy", busy, 0); chk("t4_start_ignored_valid", task_valid, 0);
    chk("t4_done_pulse", done, 0);

    // start and load while busy (slot 0 still has gap 5)
    go(2);
    cyc();
    num_cmds = 1; start = 1; res_valid = 1;
    load_valid = 1; load_addr = 1; load_key = 32'hDEADBEEF; load_value = 16'hBEEF;
    load_cmd = HT_SEARCH; load_gap = 0;
    cyc();
    start = 0; load_valid = 0;
    cyc();
    res_valid = 0;
    for (int i = 0; i < 10 && !task_valid; i++) cyc();
    chk("t5_valid1", task_valid, 1); chk("t5_key_kept", task_key, kk[1]);
    chk("t5_cmd_kept", 64'(task_cmd), 64'(HT_INSERT));
    cyc();
    chk("t5_sent", sent_cnt, 2);
    cyc();
    chk("t5_done", done, 1); chk("t5_recv", recv_cnt, 2);
    cyc();

    // last result withheld 10 cycles
    load(0, 0, HT_INSERT, 0);
    go(2);
    cyc(); res_valid = 1;
    cyc(); res_valid = 0;
    chk("t6_sent", sent_cnt, 2); chk("t6_recv1", recv_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t6_hold_busy", busy, 1); chk("t6_hold_done", done, 0);
      cyc();
    end
    res_valid = 1; cyc(); res_valid = 0;
    chk("t6_done", done, 1); chk("t6_busy_low", busy, 0); chk("t6_recv2", recv_cnt, 2);
    cyc();
    chk("t6_done_pulse", done, 0);

    // N=7 clamps to DEPTH=4 (loop_i held high where looping is compiled out)
`ifndef HT_PLAYER_LOOP_EN
    loop = 1;
`endif
    go(7); res_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t7_valid", task_valid, 1); chk("t7_key", task_key, kk[i]);
      cyc();
    end
    res_valid = 0;
    chk("t7_end_valid", task_valid, 0); chk("t7_sent", sent_cnt, 4); chk("t7_recv", recv_cnt, 4);
    cyc();
    chk("t7_done", done, 1);
    loop = 0; cyc();

`ifdef HT_PLAYER_LOOP_EN
    // three passes of three slots
    loop = 1; go(3); res_valid = 1;
    for (int i = 0; i < 9; i++) begin
      chk("t8_valid", task_valid, 1); chk("t8_key", task_key, kk[i % 3]);
      if (i == 6) loop = 0;
      cyc();
    end
    res_valid = 0;
    chk("t8_end_valid", task_valid, 0); chk("t8_sent", sent_cnt, 9); chk("t8_recv", recv_cnt, 9);
    cyc();
    chk("t8_done", done, 1);
    cyc();
`endif

    // reset mid-run, then replay from RAM that survived reset
    go(4);
    cyc();
    chk("t9_pre_valid", task_valid, 1);
    rst = 1; cyc();
    chk("t9_valid", task_valid, 0); chk("t9_busy", busy, 0); chk("t9_done", done, 0);
    chk("t9_key", task_key, 0); chk("t9_cmd", 64'(task_cmd), 0);
    chk("t9_sent", sent_cnt, 0); chk("t9_recv", recv_cnt, 0); chk("t9_res_ready", res_ready, 1);
    rst = 0; cyc();
    chk("t9_idle_busy", busy, 0); chk("t9_idle_valid", task_valid, 0);
    go(1); res_valid = 1;
    chk("t9_replay_key", task_key, kk[0]);
    cyc(); res_valid = 0;
    chk("t9_replay_sent", sent_cnt, 1);
    cyc();
    chk("t9_replay_done", done, 1); chk("t9_replay_recv", recv_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
